// File: rtl/ga_pkg.sv
// Shared definitions for the gate-array pixel engine: screen modes,
// pen index width and palette geometry, plus the per-mode pen decode.
package ga_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } ga_mode_e;

  localparam int          PEN_W      = 5;
  localparam int          BORDER_PEN = 16;
  localparam int unsigned NUM_PENS   = 17;

  // Pen index of the pixel currently at the top of the shift register.
  function automatic logic [PEN_W-1:0] decode_pen(input logic [7:0] b, input ga_mode_e m);
    logic [PEN_W-1:0] p;
    case (m)
      MODE2:   p = {4'b0000, b[7]};
      MODE1:   p = {3'b000, b[3], b[7]};
      MODE3:   p = {3'b000, b[3], b[7]};
      default: p = {1'b0, b[1], b[5], b[3], b[7]};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ga_palette.sv
// Ink/border palette: 17 entries, one write port, read indexed by the
// registered pen so a same-tick write is seen by the reader one tick later.
module ga_palette
  import ga_pkg::*;
#(
  parameter int COLW = 5
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             we,
  input  logic [PEN_W-1:0] wr_addr,
  input  logic [COLW-1:0]  wr_data,
  input  logic [PEN_W-1:0] rd_addr,
  output logic [COLW-1:0]  rd_data
);

  logic [COLW-1:0] mem [NUM_PENS];

  // Entry storage; writes beyond the border entry are dropped.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_PENS; i++) begin
        mem[PEN_W'(i)] <= '0;
      end
    end else if (we && (wr_addr < PEN_W'(NUM_PENS))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational lookup of the registered pen index.
  always_comb begin
    rd_data = '0;
    if (rd_addr < PEN_W'(NUM_PENS)) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/ga_pixel_engine.sv
// Pixel serialiser: turns fetched video bytes into per-tick pens according
// to the screen mode, then maps pens through the palette to an output colour.
module ga_pixel_engine
  import ga_pkg::*;
#(
  parameter int              COLW      = 5,
  parameter logic [COLW-1:0] BLANK_COL = '0
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             cen_16,
  input  logic             load,
  input  logic [7:0]       vid_d,
  input  logic             dispen,
  input  logic [1:0]       mode_req,
  input  logic             mode_sync,
  input  logic             force_blank,
  input  logic             pal_we,
  input  logic [4:0]       pal_addr,
  input  logic [COLW-1:0]  pal_d,
  output logic [PEN_W-1:0] pen,
  output logic [COLW-1:0]  colour,
  output logic             blank
);

  ga_mode_e        mode_cur;
  ga_mode_e        byte_mode;
  logic [7:0]      shreg;
  logic            disp_l;
  logic [1:0]      tick;
  logic            shift_en;
  logic [COLW-1:0] pal_rd;

  ga_palette #(
    .COLW(COLW)
  ) u_palette (
    .clk     (clk),
    .RESET_N (RESET_N),
    .we      (pal_we),
    .wr_addr (pal_addr),
    .wr_data (pal_d),
    .rd_addr (pen),
    .rd_data (pal_rd)
  );

  // Shift cadence: every tick in mode 2, every 2nd in mode 1, every 4th otherwise.
  always_comb begin
    shift_en = 1'b0;
    case (byte_mode)
      MODE2:   shift_en = 1'b1;
      MODE1:   shift_en = tick[0];
      default: shift_en = (tick == 2'd3);
    endcase
  end

  // Committed mode; only latched into a byte at its load, never mid-byte.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_cur <= MODE0;
    end else if (cen_16 && mode_sync) begin
      mode_cur <= ga_mode_e'(mode_req);
    end
  end

  // Byte shift register, display flag, per-byte mode and tick counter.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      shreg     <= '0;
      disp_l    <= 1'b0;
      tick      <= '0;
      byte_mode <= MODE0;
    end else if (cen_16) begin
      if (load) begin
        shreg     <= vid_d;
        disp_l    <= dispen;
        tick      <= '0;
        byte_mode <= mode_sync ? ga_mode_e'(mode_req) : mode_cur;
      end else begin
        tick <= tick + 2'd1;
        if (shift_en) begin
          shreg <= {shreg[6:0], 1'b0};
        end
      end
    end
  end

  // Pen stage: decoded pen while displaying, border pen otherwise.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      pen <= '0;
    end else if (cen_16) begin
      pen <= disp_l ? decode_pen(shreg, byte_mode) : PEN_W'(BORDER_PEN);
    end
  end

  // Colour stage: palette lookup of the registered pen, blank override last.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      colour <= BLANK_COL;
      blank  <= 1'b1;
    end else if (cen_16) begin
      if (force_blank) begin
        colour <= BLANK_COL;
        blank  <= 1'b1;
      end else begin
        colour <= pal_rd;
        blank  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ga_pixel_engine.sv
// Self-checking bench for ga_pixel_engine: directed scenarios plus random
// traffic, all compared against a byte/pixel-level reference model.
module tb_ga_pixel_engine;

  localparam int              TB_COLW  = 5;
  localparam logic [TB_COLW-1:0] TB_BLANK = 5'h1E;

  logic               clk = 1'b0;
  logic               RESET_N;
  logic               cen_16;
  logic               load;
  logic [7:0]         vid_d;
  logic               dispen;
  logic [1:0]         mode_req;
  logic               mode_sync;
  logic               force_blank;
  logic               pal_we;
  logic [4:0]         pal_addr;
  logic [TB_COLW-1:0] pal_d;
  logic [4:0]         pen;
  logic [TB_COLW-1:0] colour;
  logic               blank;

  ga_pixel_engine #(
    .COLW      (TB_COLW),
    .BLANK_COL (TB_BLANK)
  ) dut (
    .clk         (clk),
    .RESET_N     (RESET_N),
    .cen_16      (cen_16),
    .load        (load),
    .vid_d       (vid_d),
    .dispen      (dispen),
    .mode_req    (mode_req),
    .mode_sync   (mode_sync),
    .force_blank (force_blank),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_d       (pal_d),
    .pen         (pen),
    .colour      (colour),
    .blank       (blank)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state: current byte, its mode/display flag, ticks since load.
  logic [7:0]         m_byte;
  logic               m_disp;
  logic [1:0]         m_mode;
  logic [1:0]         m_cur;
  int unsigned        m_k;
  logic [4:0]         m_pen;
  logic [TB_COLW-1:0] m_col;
  logic               m_blank;
  logic [TB_COLW-1:0] m_pal [17];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pixel p of a byte is the byte shifted left p places; ticks per pixel by mode.
  function automatic logic [4:0] ref_pen(input logic [7:0] b, input logic [1:0] mode, input int unsigned k);
    int unsigned tpp;
    int unsigned p;
    logic [7:0]  s;
    tpp = (mode == 2'd2) ? 1 : (mode == 2'd1) ? 2 : 4;
    p   = k / tpp;
    s   = (p >= 8) ? 8'h00 : 8'(b << p);
    case (mode)
      2'd2:    return {4'b0000, s[7]};
      2'd1:    return {3'b000, s[3], s[7]};
      2'd3:    return {3'b000, s[3], s[7]};
      default: return {1'b0, s[1], s[5], s[3], s[7]};
    endcase
  endfunction

  task automatic model_reset();
    m_byte = '0; m_disp = 1'b0; m_mode = '0; m_cur = '0; m_k = 0;
    m_pen = '0; m_col = TB_BLANK; m_blank = 1'b1;
    for (int i = 0; i < 17; i++) m_pal[i] = '0;
  endtask

  task automatic step(input logic c, input logic ld, input logic [7:0] vd, input logic de,
                      input logic [1:0] mr, input logic ms, input logic fb,
                      input logic we, input logic [4:0] pa, input logic [TB_COLW-1:0] pd);
    logic [4:0]         n_pen;
    logic [TB_COLW-1:0] n_col;
    @(negedge clk);
    cen_16 = c; load = ld; vid_d = vd; dispen = de; mode_req = mr;
    mode_sync = ms; force_blank = fb; pal_we = we; pal_addr = pa; pal_d = pd;
    if (c) begin
      n_col = fb ? TB_BLANK : m_pal[m_pen];
      n_pen = m_disp ? ref_pen(m_byte, m_mode, m_k) : 5'd16;
      if (ld) begin
        m_byte = vd; m_disp = de; m_k = 0; m_mode = ms ? mr : m_cur;
      end else if (m_k < 64) begin
        m_k++;
      end
      if (ms) m_cur = mr;
      m_col = n_col; m_blank = fb; m_pen = n_pen;
    end
    if (we && pa < 5'd17) m_pal[pa] = pd;
    @(posedge clk);
    #1;
    check_val("pen", 32'(pen), 32'(m_pen));
    check_val("colour", 32'(colour), 32'(m_col));
    check_val("blank", 32'(blank), 32'(m_blank));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0, 2'd0, 0, 0, 0, 5'd0, '0);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic c;
      c = ($urandom % 8) != 0;
      step(c, c && ($urandom % 8 == 0), 8'($urandom), ($urandom % 8) != 0,
           2'($urandom), c && ($urandom % 16 == 0), ($urandom % 10) == 0,
           ($urandom % 6) == 0, 5'($urandom), TB_COLW'($urandom));
    end
  endtask

  logic [TB_COLW-1:0] seq036 [8];

  initial begin
    seq036 = '{5'h0B, 5'h04, 5'h0B, 5'h04, 5'h04, 5'h0B, 5'h04, 5'h0B};
    RESET_N = 1'b0; cen_16 = 0; load = 0; vid_d = '0; dispen = 0; mode_req = '0;
    mode_sync = 0; force_blank = 0; pal_we = 0; pal_addr = '0; pal_d = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pen", 32'(pen), 32'd0);
    check_val("rst_colour", 32'(colour), 32'(TB_BLANK));
    check_val("rst_blank", 32'(blank), 32'd1);
    @(negedge clk);
    RESET_N = 1'b1;

    // Inks 0/1, then a mode-2 byte 0xA5 with the mode committed at load.
    step(1, 0, 8'h00, 0, 2'd0, 0, 0, 1, 5'd0, 5'h04);
    step(1, 0, 8'h00, 0, 2'd0, 0, 0, 1, 5'd1, 5'h0B);
    step(1, 1, 8'hA5, 1, 2'd2, 1, 0, 0, 5'd0, '0);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check_val("m2_seq", 32'(colour), 32'(seq036[i]));
    end

    // Mode 0 byte 0xAA: pen 0F for 4 ticks, then 00 for 4.
    step(1, 1, 8'hAA, 1, 2'd0, 1, 0, 0, 5'd0, '0);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check_val("m0_pen", 32'(pen), (i < 4) ? 32'h0F : 32'h00);
    end

    // Mode change mid-byte only applies at the following load.
    step(1, 1, 8'h5A, 1, 2'd1, 1, 0, 0, 5'd0, '0);
    idle(2);
    step(1, 0, 8'h00, 0, 2'd2, 1, 0, 0, 5'd0, '0);
    idle(5);
    step(1, 1, 8'hC3, 1, 2'd0, 0, 0, 0, 5'd0, '0);
    idle(9);

    // Border byte, then forced blank.
    step(1, 0, 8'h00, 0, 2'd0, 0, 0, 1, 5'd16, 5'h14);
    step(1, 1, 8'hFF, 0, 2'd0, 0, 0, 0, 5'd0, '0);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check_val("border", 32'(colour), 32'h14);
    end
    step(1, 0, 8'h00, 0, 2'd0, 0, 1, 0, 5'd0, '0);
    check_val("fblank", 32'(blank), 32'd1);
    check_val("fblank_col", 32'(colour), 32'(TB_BLANK));

    // Palette write during an all-ones mode-2 byte; out-of-range write ignored.
    step(1, 1, 8'hFF, 1, 2'd2, 1, 0, 0, 5'd0, '0);
    idle(2);
    step(1, 0, 8'h00, 0, 2'd0, 0, 0, 1, 5'd1, 5'h07);
    check_val("pal_old", 32'(colour), 32'h0B);
    step(1, 0, 8'h00, 0, 2'd0, 0, 0, 1, 5'd20, 5'h1F);
    check_val("pal_new", 32'(colour), 32'h07);
    idle(3);

    rand_steps(3000);

    // Reset asserted mid-byte.
    step(1, 1, 8'h96, 1, 2'd1, 1, 0, 0, 5'd0, '0);
    idle(3);
    #2;
    RESET_N = 1'b0; cen_16 = 0; load = 0; mode_sync = 0; pal_we = 0; force_blank = 0;
    #1;
    check_val("mid_rst_colour", 32'(colour), 32'(TB_BLANK));
    check_val("mid_rst_blank", 32'(blank), 32'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    RESET_N = 1'b1;
    idle(2);
    check_val("post_rst_pen", 32'(pen), 32'd16);
    check_val("post_rst_colour", 32'(colour), 32'd0);
    check_val("post_rst_blank", 32'(blank), 32'd0);

    rand_steps(800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ga_pixel_engine.md
GA_PIXEL_ENGINE -- requirements
Module: ga_pixel_engine

Interface
REQ-001 SHALL have parameter COLW, default 5, meaning colour word width (5 = CPC hardware colour index, 12 = 4:4:4 RGB).
REQ-002 SHALL have parameter BLANK_COL, default 0, meaning colour value driven while blanked.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  system clock.
REQ-005 RESET_N  in  1  asynchronous active-low reset.
REQ-006 cen_16  in  1  16 MHz pixel-tick enable; all state except the palette advances only when it is high.
REQ-007 load  in  1  byte-load strobe; valid only with cen_16.
REQ-008 vid_d  in  8  video byte fetched from RAM.
REQ-009 dispen  in  1  display enable for the byte being loaded.
REQ-010 mode_req  in  2  requested screen mode.
REQ-011 mode_sync  in  1  mode-commit pulse (end of HSYNC); valid only with cen_16.
REQ-012 force_blank  in  1  blank override.
REQ-013 pal_we  in  1  palette write strobe, one clk wide.
REQ-014 pal_addr  in  5  pen address; 0-15 inks, 16 border, 17-31 ignored.
REQ-015 pal_d  in  COLW  palette write data.
REQ-016 pen  out  5  registered pen index of the current pixel.
REQ-017 colour  out  COLW  registered output colour.
REQ-018 blank  out  1  registered blank flag aligned with colour.

Function
REQ-019 On cen_16 & load: shift register <= vid_d, disp_l <= dispen, tick counter <= 0, byte_mode <= (mode_sync ? mode_req : mode_cur).
REQ-020 On cen_16 & mode_sync: mode_cur <= mode_req; takes effect at the next load, never mid-byte.
REQ-021 Mode 2: 8 pixels of 1 tick each; pen = {0000,b7}; shift left 1 every tick.
REQ-022 Mode 1: 4 pixels of 2 ticks each; pen = {000,b3,b7}; shift left 1 every 2nd tick.
REQ-023 Mode 0: 2 pixels of 4 ticks each; pen = {0,b1,b5,b3,b7}; shift left 1 every 4th tick.
REQ-024 Mode 3: 2 pixels of 4 ticks each; pen = {000,b3,b7}; shift left 1 every 4th tick.
REQ-025 Shift fills with zeros; with no load, pen 0 is shown once the byte is exhausted.
REQ-026 Selection: force_blank -> blank=1, colour=BLANK_COL; else disp_l=0 -> pen=16 (border); else decoded pen.
REQ-027 Pipeline: pen registered 1 tick after load; colour/blank registered 1 tick after pen; load-to-first-colour latency is 2 cen_16 ticks.
REQ-028 Palette write on any clk when pal_we is high; addresses 17-31 have no effect.
REQ-029 Palette write coinciding with a colour-register update of the same entry: colour takes the old value and the new value appears on the next tick.
REQ-030 Palette writes change colour mid-line at pixel granularity; the palette does not wait for byte boundaries.
REQ-031 force_blank is sampled at the colour stage, so it has 1 tick of latency to blank.

Reset
REQ-032 While RESET_N is low: palette entries 0-16 = 0, mode_cur = byte_mode = 0, shift register = 0, disp_l = 0, tick counter = 0, pen = 0, colour = BLANK_COL, blank = 1.
REQ-033 Reset released mid-byte SHALL resume with border output until the first load.

Structure
REQ-034 Shared package ga_pkg SHALL hold the mode enum (MODE0..MODE3), PEN_W=5, BORDER_PEN=16 and NUM_PENS=17.
REQ-035 The palette register file SHALL be sub-module ga_palette: 17 x COLW, one write port, one registered-index read.

Verification
REQ-036 Mode 2, load vid_d=0xA5, dispen=1, inks 0/1 = 0x04/0x0B -> colour sequence 0B,04,0B,04,04,0B,04,0B starting 2 ticks after load.
REQ-037 Mode 0, vid_d=0xAA -> pen 0x0F for 4 ticks, then pen 0x00 for 4 ticks.
REQ-038 mode_req=2 with mode_sync 3 ticks after a mode-1 load -> current byte stays mode 1 and the next load decodes as mode 2; mode_sync coincident with load -> that byte is mode 2.
REQ-039 dispen=0 at load, border=0x14 -> 8 ticks of colour 0x14 and pen 16; force_blank high -> BLANK_COL and blank=1 one tick later.
REQ-040 pal_we to pen 1 during a mode-2 all-ones byte -> old colour on the coincident tick, new colour from the next tick; write to address 20 leaves all entries unchanged.
REQ-041 RESET_N asserted mid-byte -> colour=BLANK_COL and blank=1 immediately; after release, border colour 0 until the next load.
